evt_timeout_mon: RTL and testbench
==================================

EVT_TIMEOUT_MON -- requirements
Module: evt_timeout_mon

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4, number of independent monitor channels (1..16).
REQ-002 SHALL provide parameter CNT_W, default 25, timeout counter width; this covers a 30,000,000-clock wait.
REQ-003 SHALL provide parameter DATA_W, default 8, width of the response data compared per channel.
REQ-004 SHALL provide the following ports, one per line (name, direction, width, meaning):
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- arm  in  NUM_CH  per-channel arm/re-arm pulse.
- timeout_val  in  NUM_CH*CNT_W  per-channel timeout in clocks; channel i uses slice [i*CNT_W +: CNT_W].
- chk_en  in  NUM_CH  per-channel data-compare enable; sampled at arm.
- exp_data  in  NUM_CH*DATA_W  per-channel expected data; sampled at arm.
- sig  in  NUM_CH  per-channel watched event signal (rising edge = event).
- data  in  NUM_CH*DATA_W  per-channel data, sampled on the event cycle.
- clr_err  in  NUM_CH  per-channel sticky-error clear.
- busy  out  NUM_CH  channel is ARMED.
- hit  out  NUM_CH  one-cycle pulse: event seen before timeout.
- timeout  out  NUM_CH  one-cycle pulse: no event before timeout.
- mismatch  out  NUM_CH  one-cycle pulse, coincident with hit: data != expected while chk_en is latched.
- err_sticky  out  NUM_CH  latched timeout/mismatch flag.
- err_any  out  1  OR of err_sticky.
- first_err_vld  out  1  first_err_ch is valid.
- first_err_ch  out  max(1,$clog2(NUM_CH))  index of the first channel to error.

Function
REQ-005 Each channel SHALL implement a two-state FSM: IDLE and ARMED.
REQ-006 sig SHALL be registered every cycle in every state; rise = sig & ~sig_q. A level already high at arm is not an event.
REQ-007 IDLE->ARMED on arm[i]. The channel SHALL load cnt = timeout_val and latch chk_en and exp_data.
REQ-008 In ARMED, rise with no arm SHALL:
- pulse hit the next cycle;
- pulse mismatch the next cycle if latched chk_en is set and data (sampled on the rise cycle) != latched exp_data;
- return the channel to IDLE.
REQ-009 In ARMED with no rise and no arm:
- cnt != 0: decrement;
- cnt == 0: pulse timeout the next cycle and return to IDLE.
- With timeout_val = T, an event is therefore accepted in any of the first T+1 ARMED cycles.
REQ-010 Priority in ARMED:
- arm beats rise and count expiry: reload cnt, re-latch, stay ARMED, emit no pulse.
- rise beats expiry on the same cycle (hit, not timeout).
REQ-011 A rise in IDLE, including on the arm cycle, SHALL be ignored.
REQ-012 busy SHALL be high exactly while the channel is ARMED.
REQ-013 hit/timeout/mismatch SHALL be registered with 1-cycle latency; hit and timeout SHALL never be high together on one channel.
REQ-014 err_sticky[i] SHALL:
- set on timeout[i] or mismatch[i];
- clear on clr_err[i];
- on a simultaneous set and clear, set wins.
REQ-015 err_any SHALL be the combinational OR of err_sticky.
REQ-016 On an error with first_err_vld low, the block SHALL set first_err_vld and capture the channel index; on simultaneous errors the lowest index wins.
REQ-017 first_err_vld SHALL clear when clr_err[first_err_ch] is applied and no new error sets in that cycle. If a new error does set in that cycle, REQ-016 recaptures that error's channel.
REQ-018 All channels SHALL operate independently and concurrently with no shared counter.
REQ-019 Counter arithmetic SHALL be unsigned CNT_W bits and SHALL never wrap below 0.

Reset
REQ-020 With rst_n low at a clock edge:
- all channels go to IDLE, cnt = 0, sig_q = 0;
- busy, hit, timeout, mismatch, err_sticky, first_err_vld = 0; first_err_ch = 0.
REQ-021 Reset mid-ARMED SHALL abort the channel with no pulse; arm is ignored while rst_n is low.

Verification
REQ-022 arm[0], timeout_val=100, sig[0] rising 50 clocks later -> hit[0] one cycle after the edge, busy[0] low, err_any=0.
REQ-023 arm[1], timeout_val=10, sig never rises -> timeout[1] on cycle 12 after arm, err_sticky[1]=1, first_err_ch=1, first_err_vld=1.
REQ-024 arm[2] with chk_en=1, exp_data=8'hA5; event with data=8'h5A -> hit[2] and mismatch[2] together, err_sticky[2]=1. Repeat with data=8'hA5 -> no mismatch.
REQ-025 Channels 1 and 3 time out on the same cycle -> first_err_ch=1. clr_err[1] the same cycle as a new timeout[3] -> first_err_vld stays 1, first_err_ch=3.
REQ-026 Re-arm channel 0 at count 2 of timeout_val=5 -> no timeout pulse, expiry moves to 6 cycles after the re-arm. rise on the exact expiry cycle -> hit, not timeout.
REQ-027 rst_n low while channel 0 is ARMED, then sig rises -> no pulse, busy=0. sig already high at arm -> no hit until a fresh rising edge.

Source files
------------

// File: rtl/evt_timeout_mon.sv
// Multi-channel event timeout monitor: each channel waits for a rising edge on its
// watched signal within a programmable window and optionally checks the data it carries.
module evt_timeout_mon #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 25,
  parameter int DATA_W = 8,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        arm,
  input  logic [NUM_CH*CNT_W-1:0]  timeout_val,
  input  logic [NUM_CH-1:0]        chk_en,
  input  logic [NUM_CH*DATA_W-1:0] exp_data,
  input  logic [NUM_CH-1:0]        sig,
  input  logic [NUM_CH*DATA_W-1:0] data,
  input  logic [NUM_CH-1:0]        clr_err,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        hit,
  output logic [NUM_CH-1:0]        timeout,
  output logic [NUM_CH-1:0]        mismatch,
  output logic [NUM_CH-1:0]        err_sticky,
  output logic                     err_any,
  output logic                     first_err_vld,
  output logic [CH_W-1:0]          first_err_ch
);

  typedef enum logic {S_IDLE = 1'b0, S_ARMED = 1'b1} state_t;

  state_t            r_state     [NUM_CH];
  state_t            w_state_nxt [NUM_CH];
  logic [CNT_W-1:0]  r_cnt       [NUM_CH];
  logic [CNT_W-1:0]  w_cnt_nxt   [NUM_CH];
  logic [DATA_W-1:0] r_exp       [NUM_CH];

  logic [NUM_CH-1:0] r_sig_q;
  logic [NUM_CH-1:0] r_chk_en;
  logic [NUM_CH-1:0] r_hit;
  logic [NUM_CH-1:0] r_timeout;
  logic [NUM_CH-1:0] r_mismatch;
  logic [NUM_CH-1:0] r_err_sticky;
  logic              r_first_vld;
  logic [CH_W-1:0]   r_first_ch;

  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_hit_nxt;
  logic [NUM_CH-1:0] w_to_nxt;
  logic [NUM_CH-1:0] w_mm_nxt;
  logic [NUM_CH-1:0] w_err_set;
  logic [CH_W-1:0]   w_first_lo;

  // Per-channel next state: arm outranks an event, an event outranks expiry.
  always_comb begin
    w_rise    = sig & ~r_sig_q;
    w_hit_nxt = '0;
    w_to_nxt  = '0;
    w_mm_nxt  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        S_IDLE: begin
          if (arm[i]) begin
            w_state_nxt[i] = S_ARMED;
            w_cnt_nxt[i]   = timeout_val[i*CNT_W +: CNT_W];
          end
        end
        S_ARMED: begin
          if (arm[i]) begin
            w_cnt_nxt[i] = timeout_val[i*CNT_W +: CNT_W];
          end else if (w_rise[i]) begin
            w_hit_nxt[i]   = 1'b1;
            w_mm_nxt[i]    = r_chk_en[i] && (data[i*DATA_W +: DATA_W] != r_exp[i]);
            w_state_nxt[i] = S_IDLE;
          end else if (r_cnt[i] != '0) begin
            w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
          end else begin
            w_to_nxt[i]    = 1'b1;
            w_state_nxt[i] = S_IDLE;
          end
        end
        default: w_state_nxt[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (arm[i]) r_exp[i] <= exp_data[i*DATA_W +: DATA_W];
    end
  end

  assign w_err_set = r_timeout | r_mismatch;

  // Lowest erroring channel index takes precedence.
  always_comb begin
    w_first_lo = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_err_set[i]) w_first_lo = CH_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sig_q      <= '0;
      r_chk_en     <= '0;
      r_hit        <= '0;
      r_timeout    <= '0;
      r_mismatch   <= '0;
      r_err_sticky <= '0;
      r_first_vld  <= 1'b0;
      r_first_ch   <= '0;
    end else begin
      r_sig_q      <= sig;
      r_chk_en     <= (arm & chk_en) | (~arm & r_chk_en);
      r_hit        <= w_hit_nxt;
      r_timeout    <= w_to_nxt;
      r_mismatch   <= w_mm_nxt;
      r_err_sticky <= w_err_set | (r_err_sticky & ~clr_err);
      if ((w_err_set != '0) && (!r_first_vld || clr_err[r_first_ch])) begin
        r_first_vld <= 1'b1;
        r_first_ch  <= w_first_lo;
      end else if (r_first_vld && clr_err[r_first_ch]) begin
        r_first_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) busy[i] = (r_state[i] == S_ARMED);
  end

  assign hit           = r_hit;
  assign timeout       = r_timeout;
  assign mismatch      = r_mismatch;
  assign err_sticky    = r_err_sticky;
  assign err_any       = |r_err_sticky;
  assign first_err_vld = r_first_vld;
  assign first_err_ch  = r_first_ch;

endmodule

// File: tb/tb_evt_timeout_mon.sv
// Bench for evt_timeout_mon: directed scenarios plus randomized traffic checked
// against a deadline-based reference model.
module tb_evt_timeout_mon;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 25;
  localparam int DATA_W = 8;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_CH-1:0]        arm = '0;
  logic [NUM_CH*CNT_W-1:0]  timeout_val = '0;
  logic [NUM_CH-1:0]        chk_en = '0;
  logic [NUM_CH*DATA_W-1:0] exp_data = '0;
  logic [NUM_CH-1:0]        sig = '0;
  logic [NUM_CH*DATA_W-1:0] data = '0;
  logic [NUM_CH-1:0]        clr_err = '0;
  logic [NUM_CH-1:0]        busy, hit, timeout, mismatch, err_sticky;
  logic                     err_any, first_err_vld;
  logic [1:0]               first_err_ch;

  int total = 0;
  int bad   = 0;

  evt_timeout_mon #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .timeout_val(timeout_val), .chk_en(chk_en),
    .exp_data(exp_data), .sig(sig), .data(data), .clr_err(clr_err), .busy(busy),
    .hit(hit), .timeout(timeout), .mismatch(mismatch), .err_sticky(err_sticky),
    .err_any(err_any), .first_err_vld(first_err_vld), .first_err_ch(first_err_ch)
  );

  always #5 clk = ~clk;

  // Reference model: an armed channel owns an absolute deadline cycle rather than a counter.
  longint            cyc = 0;
  longint            m_deadline [NUM_CH];
  logic [DATA_W-1:0] m_exp [NUM_CH];
  logic [NUM_CH-1:0] m_armed = '0, m_chk = '0, m_prev = '0;
  logic [NUM_CH-1:0] m_hit = '0, m_to = '0, m_mm = '0, m_sticky = '0;
  logic [NUM_CH-1:0] m_errs, m_rise;
  logic              m_fvld = 1'b0;
  int                m_fch = 0;

  always @(posedge clk) begin
    m_errs = m_to | m_mm;
    m_rise = sig & ~m_prev;
    if (!rst_n) begin
      m_armed = '0; m_chk = '0; m_hit = '0; m_to = '0; m_mm = '0; m_sticky = '0;
      m_fvld = 1'b0; m_fch = 0;
    end else begin
      m_sticky = m_errs | (m_sticky & ~clr_err);
      if (m_errs != '0 && (!m_fvld || clr_err[m_fch])) begin
        m_fvld = 1'b1;
        for (int k = 0; k < NUM_CH; k++) if (m_errs[k]) begin m_fch = k; break; end
      end else if (m_fvld && clr_err[m_fch]) begin
        m_fvld = 1'b0;
      end
      m_hit = '0; m_to = '0; m_mm = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (arm[c]) begin
          m_armed[c]    = 1'b1;
          m_deadline[c] = cyc + 1 + longint'(timeout_val[c*CNT_W +: CNT_W]);
          m_chk[c]      = chk_en[c];
          m_exp[c]      = exp_data[c*DATA_W +: DATA_W];
        end else if (m_armed[c]) begin
          if (m_rise[c]) begin
            m_hit[c]   = 1'b1;
            m_mm[c]    = m_chk[c] && (data[c*DATA_W +: DATA_W] !== m_exp[c]);
            m_armed[c] = 1'b0;
          end else if (cyc == m_deadline[c]) begin
            m_to[c]    = 1'b1;
            m_armed[c] = 1'b0;
          end
        end
      end
    end
    m_prev = rst_n ? sig : '0;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input int tv, input bit ce, input logic [DATA_W-1:0] ed);
    timeout_val[ch*CNT_W +: CNT_W] = CNT_W'(tv);
    chk_en[ch] = ce;
    exp_data[ch*DATA_W +: DATA_W] = ed;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; arm = '0; sig = '0; clr_err = '0; chk_en = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; arm = 4'b1111; timeout_val = '1;
    tick(); tick(); tick();
    total++;
    if ({busy, hit, timeout, mismatch, err_sticky, err_any, first_err_vld, first_err_ch} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {busy, hit, timeout, mismatch, err_sticky, err_any, first_err_vld, first_err_ch});
    end
    arm = '0; timeout_val = '0;
  endtask

  task automatic test_hit();
    do_reset();
    set_ch(0, 100, 1'b0, 8'h00);
    arm[0] = 1'b1; tick(); arm[0] = 1'b0;
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL hit_busy got=%b want=1", busy[0]); end
    repeat (49) tick();
    sig[0] = 1'b1; tick();
    total++; if (hit !== 4'b0001) begin bad++; $display("FAIL hit_pulse got=%b want=0001", hit); end
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL hit_idle got=%b want=0", busy[0]); end
    total++; if (err_any !== 1'b0) begin bad++; $display("FAIL hit_err_any got=%b want=0", err_any); end
    sig[0] = 1'b0; tick();
    total++; if (hit !== 4'b0000) begin bad++; $display("FAIL hit_one_cycle got=%b want=0000", hit); end
  endtask

  task automatic test_timeout();
    do_reset();
    set_ch(1, 10, 1'b0, 8'h00);
    arm[1] = 1'b1; tick(); arm[1] = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      total++;
      if (timeout[1] !== 1'b0) begin bad++; $display("FAIL to_early cyc=%0d got=%b want=0", k, timeout[1]); end
      tick();
    end
    total++; if (timeout !== 4'b0010) begin bad++; $display("FAIL to_pulse got=%b want=0010", timeout); end
    total++; if (hit !== 4'b0000) begin bad++; $display("FAIL to_no_hit got=%b want=0000", hit); end
    tick();
    total++; if (err_sticky !== 4'b0010) begin bad++; $display("FAIL to_sticky got=%b want=0010", err_sticky); end
    total++; if (first_err_vld !== 1'b1 || first_err_ch !== 2'd1) begin
      bad++; $display("FAIL to_first got=%b/%0d want=1/1", first_err_vld, first_err_ch); end
    clr_err[1] = 1'b1; tick(); clr_err = '0;
    total++; if ({err_sticky, err_any, first_err_vld} !== 6'b0) begin
      bad++; $display("FAIL to_clear got=%b want=0", {err_sticky, err_any, first_err_vld}); end
  endtask

  task automatic test_mismatch();
    do_reset();
    set_ch(2, 20, 1'b1, 8'hA5);
    arm[2] = 1'b1; tick(); arm[2] = 1'b0;
    tick();
    data[2*DATA_W +: DATA_W] = 8'h5A; sig[2] = 1'b1; tick(); sig[2] = 1'b0;
    total++; if (hit !== 4'b0100 || mismatch !== 4'b0100) begin
      bad++; $display("FAIL mm_bad got=%b/%b want=0100/0100", hit, mismatch); end
    tick();
    total++; if (err_sticky !== 4'b0100 || first_err_ch !== 2'd2) begin
      bad++; $display("FAIL mm_sticky got=%b/%0d want=0100/2", err_sticky, first_err_ch); end
    arm[2] = 1'b1; tick(); arm[2] = 1'b0;
    data[2*DATA_W +: DATA_W] = 8'hA5; sig[2] = 1'b1; tick(); sig[2] = 1'b0;
    total++; if (hit !== 4'b0100 || mismatch !== 4'b0000) begin
      bad++; $display("FAIL mm_good got=%b/%b want=0100/0000", hit, mismatch); end
  endtask

  task automatic test_first_err();
    int k;
    do_reset();
    set_ch(1, 10, 1'b0, 8'h00);
    set_ch(3, 10, 1'b0, 8'h00);
    arm = 4'b1010; tick(); arm = '0;
    for (k = 0; k < 20 && timeout == '0; k++) tick();
    total++; if (timeout !== 4'b1010) begin bad++; $display("FAIL fe_both got=%b want=1010", timeout); end
    tick();
    total++; if (first_err_vld !== 1'b1 || first_err_ch !== 2'd1) begin
      bad++; $display("FAIL fe_lowest got=%b/%0d want=1/1", first_err_vld, first_err_ch); end
    set_ch(3, 3, 1'b0, 8'h00);
    arm[3] = 1'b1; tick(); arm[3] = 1'b0;
    for (k = 0; k < 20 && !timeout[3]; k++) tick();
    total++; if (timeout[3] !== 1'b1) begin bad++; $display("FAIL fe_wait got=%b want=1", timeout[3]); end
    clr_err[1] = 1'b1; tick(); clr_err = '0;
    total++; if (first_err_vld !== 1'b1 || first_err_ch !== 2'd3) begin
      bad++; $display("FAIL fe_recapture got=%b/%0d want=1/3", first_err_vld, first_err_ch); end
    total++; if (err_sticky !== 4'b1000) begin bad++; $display("FAIL fe_sticky got=%b want=1000", err_sticky); end
    clr_err[3] = 1'b1; tick(); clr_err = '0;
    total++; if (first_err_vld !== 1'b0 || err_any !== 1'b0) begin
      bad++; $display("FAIL fe_clear got=%b/%b want=0/0", first_err_vld, err_any); end
  endtask

  task automatic test_rearm();
    do_reset();
    set_ch(0, 5, 1'b0, 8'h00);
    arm[0] = 1'b1; tick(); arm[0] = 1'b0;
    repeat (3) tick();
    arm[0] = 1'b1; tick(); arm[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      total++;
      if (timeout[0] !== 1'b0 || busy[0] !== 1'b1) begin
        bad++; $display("FAIL rearm_hold cyc=%0d got=%b/%b want=0/1", k, timeout[0], busy[0]); end
      tick();
    end
    sig[0] = 1'b1; tick(); sig[0] = 1'b0;
    total++; if (hit[0] !== 1'b1 || timeout[0] !== 1'b0) begin
      bad++; $display("FAIL rearm_edge got=%b/%b want=1/0", hit[0], timeout[0]); end
    arm[0] = 1'b1; tick(); arm[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      total++;
      if (timeout[0] !== 1'b0) begin bad++; $display("FAIL rearm_early cyc=%0d got=%b want=0", k, timeout[0]); end
      tick();
    end
    total++; if (timeout[0] !== 1'b1) begin bad++; $display("FAIL rearm_expire got=%b want=1", timeout[0]); end
  endtask

  task automatic test_reset_abort();
    do_reset();
    set_ch(0, 50, 1'b0, 8'h00);
    arm[0] = 1'b1; tick(); arm[0] = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0; arm[0] = 1'b1; tick();
    arm[0] = 1'b0; rst_n = 1'b1;
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy[0]); end
    tick();
    sig[0] = 1'b1; tick();
    tick();
    total++; if (hit[0] !== 1'b0 || timeout[0] !== 1'b0 || busy[0] !== 1'b0) begin
      bad++; $display("FAIL abort_no_pulse got=%b%b%b want=000", hit[0], timeout[0], busy[0]); end
    arm[0] = 1'b1; tick(); arm[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++; if (hit[0] !== 1'b0) begin bad++; $display("FAIL level_no_hit got=%b want=0", hit[0]); end
      tick();
    end
    sig[0] = 1'b0; tick();
    sig[0] = 1'b1; tick();
    total++; if (hit[0] !== 1'b1) begin bad++; $display("FAIL level_fresh_edge got=%b want=1", hit[0]); end
    sig[0] = 1'b0; tick();
    arm[0] = 1'b1; sig[0] = 1'b1; tick(); arm[0] = 1'b0;
    tick();
    total++; if (hit[0] !== 1'b0 || busy[0] !== 1'b1) begin
      bad++; $display("FAIL arm_cycle_edge got=%b/%b want=0/1", hit[0], busy[0]); end
    sig[0] = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int c = 0; c < NUM_CH; c++) begin
        arm[c]     = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 2) == 0) sig[c] = ~sig[c];
        clr_err[c] = ($urandom_range(0, 7) == 0);
        set_ch(c, int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) != 0) ? 8'hA5 : 8'h5A);
        data[c*DATA_W +: DATA_W] = ($urandom_range(0, 1) != 0) ? 8'hA5 : 8'h5A;
      end
      tick();
      total++;
      if (busy !== m_armed || hit !== m_hit || timeout !== m_to || mismatch !== m_mm) begin
        bad++;
        $display("FAIL rnd_ch n=%0d got=%b/%b/%b/%b want=%b/%b/%b/%b", n, busy, hit, timeout, mismatch,
                 m_armed, m_hit, m_to, m_mm);
      end
      total++;
      if (err_sticky !== m_sticky || err_any !== (|m_sticky) || first_err_vld !== m_fvld ||
          (m_fvld && first_err_ch !== 2'(m_fch))) begin
        bad++;
        $display("FAIL rnd_err n=%0d got=%b/%b/%b/%0d want=%b/%b/%b/%0d", n, err_sticky, err_any,
                 first_err_vld, first_err_ch, m_sticky, |m_sticky, m_fvld, m_fch);
      end
    end
    rst_n = 1'b1; arm = '0; sig = '0; clr_err = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_hit();
    test_timeout();
    test_mismatch();
    test_first_err();
    test_rearm();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
